// File: rtl/wbarb_pkg.sv
// Shared types and constants for the regfile write-port arbiter.
// Edit STARVE_MAX / NREGS here to retune the whole slice.
package wbarb_pkg;

    localparam int STARVE_MAX = 4;
    localparam int NREGS      = 32;
    localparam int STARVE_W   = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        FORCE
    } arb_state_e;

    typedef logic [4:0] reg_idx_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-result scoreboard: one bit per register awaiting an MDU write,
// looked up combinationally for decode RAW/WAW hazards.
module rf_scoreboard
    import wbarb_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     set_en,
    input  reg_idx_t set_idx,
    input  logic     clr_en,
    input  reg_idx_t clr_idx,
    input  reg_idx_t rs1,
    input  reg_idx_t rs2,
    input  reg_idx_t rd,
    output logic     hazard
);

    logic [NREGS-1:0] pending;

    // A new long op to the same register outranks the result retiring this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (set_en && set_idx == reg_idx_t'(i)) begin
                    pending[i] <= 1'b1;
                end else if (clr_en && clr_idx == reg_idx_t'(i)) begin
                    pending[i] <= 1'b0;
                end
            end
            pending[0] <= 1'b0;
        end
    end

    assign hazard = pending[rs1] | pending[rs2] | pending[rd];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single regfile write port between WB and the MDU, with a
// starvation guard. Define WBARB_PERF_EN to add saturating perf_* counters.
module regfile_wb_arbiter
    import wbarb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  reg_idx_t    wb_rd,
    input  logic [31:0] wb_data,
    output logic        wb_hold,
    input  logic        mdu_valid,
    input  reg_idx_t    mdu_rd,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    input  logic        issue_valid,
    input  logic        issue_long,
    input  reg_idx_t    issue_rd,
    input  reg_idx_t    dec_rs1,
    input  reg_idx_t    dec_rs2,
    input  reg_idx_t    dec_rd,
    output logic        dec_stall,
    output logic        rf_load,
    output reg_idx_t    rf_dest,
    output logic [31:0] rf_in
`ifdef WBARB_PERF_EN
    ,
    output logic [31:0] perf_wb_grants,
    output logic [31:0] perf_mdu_grants,
    output logic [31:0] perf_force_events,
    output logic [31:0] perf_stall_cycles
`endif
);

    arb_state_e          state;
    logic [STARVE_W-1:0] starve_cnt;
    logic                force_mode;
    logic                wb_grant;
    logic                mdu_grant;
    logic                sb_hazard;

    // Grants are gated by rst so nothing reaches the regfile in a reset cycle.
    assign force_mode = (state == FORCE);
    assign wb_grant   = !rst && wb_valid && !force_mode;
    assign mdu_grant  = !rst && mdu_valid && (!wb_valid || force_mode);
    assign mdu_ready  = mdu_grant;
    assign wb_hold    = !rst && force_mode;
    assign dec_stall  = !rst && sb_hazard;

    always_comb begin
        rf_load = 1'b0;
        rf_dest = '0;
        rf_in   = '0;
        if (mdu_grant) begin
            rf_load = (mdu_rd != '0);
            rf_dest = mdu_rd;
            rf_in   = mdu_data;
        end else if (wb_grant) begin
            rf_load = (wb_rd != '0);
            rf_dest = wb_rd;
            rf_in   = wb_data;
        end
    end

    // starve_cnt counts consecutive cycles the MDU lost to WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mdu_valid && !mdu_grant) begin
                        starve_cnt <= STARVE_W'(1);
                        state      <= (STARVE_MAX <= 1) ? FORCE : WAIT;
                    end
                end
                WAIT: begin
                    if (!mdu_valid || mdu_grant) begin
                        state      <= IDLE;
                        starve_cnt <= '0;
                    end else begin
                        starve_cnt <= starve_cnt + 1'b1;
                        if (starve_cnt == STARVE_W'(STARVE_MAX - 1)) begin
                            state <= FORCE;
                        end
                    end
                end
                FORCE: begin
                    state      <= IDLE;
                    starve_cnt <= '0;
                end
                default: begin
                    state      <= IDLE;
                    starve_cnt <= '0;
                end
            endcase
        end
    end

    wait_keeps_mdu_valid: assert property (
        @(posedge clk) disable iff (rst) (state == WAIT) |-> mdu_valid
    );

    rf_scoreboard u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_en  (issue_valid && issue_long && issue_rd != '0),
        .set_idx (issue_rd),
        .clr_en  (mdu_grant),
        .clr_idx (mdu_rd),
        .rs1     (dec_rs1),
        .rs2     (dec_rs2),
        .rd      (dec_rd),
        .hazard  (sb_hazard)
    );

`ifdef WBARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_wb_grants    <= '0;
            perf_mdu_grants   <= '0;
            perf_force_events <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (wb_grant && perf_wb_grants != '1)
                perf_wb_grants <= perf_wb_grants + 1'b1;
            if (mdu_grant && perf_mdu_grants != '1)
                perf_mdu_grants <= perf_mdu_grants + 1'b1;
            if (force_mode && perf_force_events != '1)
                perf_force_events <= perf_force_events + 1'b1;
            if (dec_stall && perf_stall_cycles != '1)
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected outputs are queued as each
// step is driven and popped/compared at the following negedge.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_hold;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        issue_valid;
    logic        issue_long;
    logic [4:0]  issue_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        dec_stall;
    logic        rf_load;
    logic [4:0]  rf_dest;
    logic [31:0] rf_in;

    typedef struct {
        string       tag;
        logic        load;
        logic [4:0]  dest;
        logic [31:0] din;
        logic        hold;
        logic        ready;
        logic        stall;
    } exp_t;

    exp_t expq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .wb_hold     (wb_hold),
        .mdu_valid   (mdu_valid),
        .mdu_rd      (mdu_rd),
        .mdu_data    (mdu_data),
        .mdu_ready   (mdu_ready),
        .issue_valid (issue_valid),
        .issue_long  (issue_long),
        .issue_rd    (issue_rd),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_rd      (dec_rd),
        .dec_stall   (dec_stall),
        .rf_load     (rf_load),
        .rf_dest     (rf_dest),
        .rf_in       (rf_in)
    );

    task automatic applyStimulus(
        input string tag, input logic r,
        input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
        input logic mv, input logic [4:0] mrd, input logic [31:0] md,
        input logic il, input logic [4:0] ird,
        input logic e_load, input logic [4:0] e_dest, input logic [31:0] e_in,
        input logic e_hold, input logic e_ready, input logic e_stall);
        exp_t e;
        @(posedge clk);
        #1;
        rst         = r;
        wb_valid    = wv;
        wb_rd       = wrd;
        wb_data     = wd;
        mdu_valid   = mv;
        mdu_rd      = mrd;
        mdu_data    = md;
        issue_valid = il;
        issue_long  = il;
        issue_rd    = ird;
        e.tag   = tag;
        e.load  = e_load;
        e.dest  = e_dest;
        e.din   = e_in;
        e.hold  = e_hold;
        e.ready = e_ready;
        e.stall = e_stall;
        expq.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        @(negedge clk);
        if (expq.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL scoreboard_empty: got 0 entries want 1");
        end else begin
            e = expq.pop_front();
            vectors++;
            assert (rf_load === e.load) else begin
                miscompares++;
                $error("[TB] FAIL %s rf_load: got %b want %b", e.tag, rf_load, e.load);
            end
            vectors++;
            assert (wb_hold === e.hold) else begin
                miscompares++;
                $error("[TB] FAIL %s wb_hold: got %b want %b", e.tag, wb_hold, e.hold);
            end
            vectors++;
            assert (mdu_ready === e.ready) else begin
                miscompares++;
                $error("[TB] FAIL %s mdu_ready: got %b want %b", e.tag, mdu_ready, e.ready);
            end
            vectors++;
            assert (dec_stall === e.stall) else begin
                miscompares++;
                $error("[TB] FAIL %s dec_stall: got %b want %b", e.tag, dec_stall, e.stall);
            end
            if (e.load) begin
                vectors++;
                assert (rf_dest === e.dest) else begin
                    miscompares++;
                    $error("[TB] FAIL %s rf_dest: got %0d want %0d", e.tag, rf_dest, e.dest);
                end
                vectors++;
                assert (rf_in === e.din) else begin
                    miscompares++;
                    $error("[TB] FAIL %s rf_in: got %h want %h", e.tag, rf_in, e.din);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0;
        issue_valid = 1'b0; issue_long = 1'b0; issue_rd = '0;
        dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;

        // reset: outputs quiet even with requests present
        applyStimulus("rst_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput();
        applyStimulus("rst_req", 1, 1, 3, 32'h1111, 1, 4, 32'h2222, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput();

        // WB write passes straight through
        applyStimulus("t1_wb", 0, 1, 5, 32'hA5A5, 0, 0, 0, 0, 0, 1, 5, 32'hA5A5, 0, 0, 0); checkOutput();

        // x0 destinations never load
        applyStimulus("t2_wb_x0", 0, 1, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput();
        applyStimulus("t2_mdu_x0", 0, 0, 0, 0, 1, 0, 32'hDEAD, 0, 0, 0, 0, 0, 0, 1, 0); checkOutput();

        // starvation: four lost cycles then a forced MDU write
        for (int i = 0; i < 4; i++) begin
            applyStimulus($sformatf("t3_lost%0d", i), 0, 1, 3, 32'h3333, 1, 7, 32'h7777, 0, 0,
                          1, 3, 32'h3333, 0, 0, 0);
            checkOutput();
        end
        applyStimulus("t3_force", 0, 1, 3, 32'h3333, 1, 7, 32'h7777, 0, 0, 1, 7, 32'h7777, 1, 1, 0); checkOutput();
        applyStimulus("t3_after", 0, 1, 3, 32'h3333, 0, 0, 0, 0, 0, 1, 3, 32'h3333, 0, 0, 0); checkOutput();

        // RAW on rs2 until the MDU result for x9 retires
        dec_rs2 = 5'd9;
        applyStimulus("t4_issue", 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0); checkOutput();
        applyStimulus("t4_pending", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); checkOutput();
        applyStimulus("t4_lost", 0, 1, 4, 32'h4444, 1, 9, 32'h9999, 0, 0, 1, 4, 32'h4444, 0, 0, 1); checkOutput();
        applyStimulus("t4_xfer", 0, 0, 0, 0, 1, 9, 32'h9999, 0, 0, 1, 9, 32'h9999, 0, 1, 1); checkOutput();
        applyStimulus("t4_cleared", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput();

        // set and clear of x9 in one cycle: set wins
        applyStimulus("t5_issue", 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0); checkOutput();
        applyStimulus("t5_pending", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); checkOutput();
        applyStimulus("t5_setclr", 0, 0, 0, 0, 1, 9, 32'h5555, 1, 9, 1, 9, 32'h5555, 0, 1, 1); checkOutput();
        applyStimulus("t5_set_wins", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); checkOutput();
        applyStimulus("t5_clr", 0, 0, 0, 0, 1, 9, 32'h6666, 0, 0, 1, 9, 32'h6666, 0, 1, 1); checkOutput();
        applyStimulus("t5_cleared", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput();

        // WAW via dec_rd, RAW via rs1, and x0 issue never pends
        dec_rs2 = 5'd0;
        dec_rd  = 5'd12;
        applyStimulus("waw_issue", 0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0, 0, 0, 0); checkOutput();
        applyStimulus("waw_stall", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); checkOutput();
        dec_rd  = 5'd0;
        dec_rs1 = 5'd12;
        applyStimulus("raw_rs1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); checkOutput();
        dec_rs1 = 5'd0;
        applyStimulus("x0_issue", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0); checkOutput();
        applyStimulus("x0_nostall", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput();

        // reset while in FORCE abandons the write and clears pending
        dec_rd = 5'd12;
        for (int i = 0; i < 4; i++) begin
            applyStimulus($sformatf("t6_lost%0d", i), 0, 1, 3, 32'h3333, 1, 7, 32'h7777, 0, 0,
                          1, 3, 32'h3333, 0, 0, 1);
            checkOutput();
        end
        applyStimulus("t6_rst_force", 1, 1, 3, 32'h3333, 1, 7, 32'h7777, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput();
        applyStimulus("t6_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput();
        applyStimulus("t6_wb_ok", 0, 1, 5, 32'h0001, 0, 0, 0, 0, 0, 1, 5, 32'h0001, 0, 0, 0); checkOutput();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
